// File: rtl/gba_rom_responder.sv
// Cartridge-side GBA ROM bus responder: synchronizes host strobes, latches the
// halfword address, autoincrements per read and fetches data from a backing store.
module gba_rom_responder #(
  parameter int SYNC_STAGES   = 2,
  parameter int FETCH_TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        nCS,
  input  logic        nRD,
  input  logic        nWR,
  input  logic [23:0] add_dat_in,
  output logic [15:0] ad_out,
  output logic        ad_oe,
  output logic [23:0] mem_addr,
  output logic        mem_rd_req,
  input  logic [15:0] mem_data,
  input  logic        mem_valid,
  output logic        busy,
  output logic        err_underrun,
  output logic        err_timeout,
  output logic        wr_ignored
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_READY = 2'd2;
  localparam logic [1:0] S_DRIVE = 2'd3;
  localparam int TW = $clog2(FETCH_TIMEOUT + 1);

  logic [SYNC_STAGES-1:0]       cs_sync_q, cs_sync_d, rd_sync_q, rd_sync_d, wr_sync_q, wr_sync_d;
  logic [SYNC_STAGES-1:0][23:0] ad_sync_q, ad_sync_d;
  logic        cs_prev_q, cs_prev_d, rd_prev_q, rd_prev_d, wr_prev_q, wr_prev_d;
  logic [1:0]  state_q, state_d;
  logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
  logic [15:0] data_buf_q, data_buf_d, ad_out_q, ad_out_d;
  logic [23:0] mem_addr_q, mem_addr_d;
  logic        ad_oe_q, ad_oe_d, mem_rd_req_q, mem_rd_req_d, busy_q, busy_d;
  logic        err_underrun_q, err_underrun_d, err_timeout_q, err_timeout_d;
  logic        wr_ignored_q, wr_ignored_d;

  logic        cs_s, rd_s, wr_s, cs_fall, cs_rise, rd_rise, wr_fall, fetch_done;
  logic [23:0] ad_s;
  logic [15:0] fetch_data;

  assign cs_s = cs_sync_q[SYNC_STAGES-1];
  assign rd_s = rd_sync_q[SYNC_STAGES-1];
  assign wr_s = wr_sync_q[SYNC_STAGES-1];
  assign ad_s = ad_sync_q[SYNC_STAGES-1];

  assign cs_fall = cs_prev_q & ~cs_s;
  assign cs_rise = ~cs_prev_q & cs_s;
  assign rd_rise = ~rd_prev_q & rd_s;
  assign wr_fall = wr_prev_q & ~wr_s;

  // A timed-out fetch completes like a normal one but with all-ones data.
  assign fetch_done = mem_valid | (tmo_cnt_q == TW'(FETCH_TIMEOUT - 1));
  assign fetch_data = mem_valid ? mem_data : 16'hFFFF;

  always_comb begin
    cs_sync_d      = {cs_sync_q[SYNC_STAGES-2:0], nCS};
    rd_sync_d      = {rd_sync_q[SYNC_STAGES-2:0], nRD};
    wr_sync_d      = {wr_sync_q[SYNC_STAGES-2:0], nWR};
    ad_sync_d      = {ad_sync_q[SYNC_STAGES-2:0], add_dat_in};
    cs_prev_d      = cs_s;
    rd_prev_d      = rd_s;
    wr_prev_d      = wr_s;
    state_d        = state_q;
    tmo_cnt_d      = tmo_cnt_q;
    data_buf_d     = data_buf_q;
    ad_out_d       = ad_out_q;
    ad_oe_d        = ad_oe_q;
    mem_addr_d     = mem_addr_q;
    mem_rd_req_d   = 1'b0;
    err_underrun_d = err_underrun_q;
    err_timeout_d  = err_timeout_q;
    wr_ignored_d   = wr_fall & ~cs_s;

    case (state_q)
      S_IDLE: begin
        ad_oe_d = 1'b0;
        if (cs_fall) begin
          mem_addr_d   = ad_s;
          state_d      = S_FETCH;
          mem_rd_req_d = 1'b1;
          tmo_cnt_d    = '0;
        end
      end
      S_FETCH: begin
        // Host strobed early: drive stale data now, swap in fresh data on arrival.
        if (!rd_s) begin
          err_underrun_d = 1'b1;
          ad_oe_d        = 1'b1;
          ad_out_d       = data_buf_q;
        end else begin
          ad_oe_d = 1'b0;
        end
        if (fetch_done) begin
          data_buf_d = fetch_data;
          if (!mem_valid) err_timeout_d = 1'b1;
          if (!rd_s) begin
            ad_out_d = fetch_data;
            state_d  = S_DRIVE;
          end else begin
            state_d  = S_READY;
          end
        end else begin
          tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
      end
      S_READY: begin
        if (!rd_s) begin
          ad_out_d = data_buf_q;
          ad_oe_d  = 1'b1;
          state_d  = S_DRIVE;
        end
      end
      S_DRIVE: begin
        if (rd_rise) begin
          ad_oe_d      = 1'b0;
          mem_addr_d   = {mem_addr_q[23:16], mem_addr_q[15:0] + 16'd1};
          state_d      = S_FETCH;
          mem_rd_req_d = 1'b1;
          tmo_cnt_d    = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Deselect beats everything, including a same-cycle nRD rise.
    if (cs_rise) begin
      ad_oe_d      = 1'b0;
      state_d      = S_IDLE;
      mem_addr_d   = mem_addr_q;
      mem_rd_req_d = 1'b0;
    end

    busy_d = (state_d == S_FETCH);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cs_sync_q      <= '1;
      rd_sync_q      <= '1;
      wr_sync_q      <= '1;
      ad_sync_q      <= '0;
      cs_prev_q      <= 1'b1;
      rd_prev_q      <= 1'b1;
      wr_prev_q      <= 1'b1;
      state_q        <= S_IDLE;
      tmo_cnt_q      <= '0;
      data_buf_q     <= '0;
      ad_out_q       <= '0;
      ad_oe_q        <= 1'b0;
      mem_addr_q     <= '0;
      mem_rd_req_q   <= 1'b0;
      busy_q         <= 1'b0;
      err_underrun_q <= 1'b0;
      err_timeout_q  <= 1'b0;
      wr_ignored_q   <= 1'b0;
    end else begin
      cs_sync_q      <= cs_sync_d;
      rd_sync_q      <= rd_sync_d;
      wr_sync_q      <= wr_sync_d;
      ad_sync_q      <= ad_sync_d;
      cs_prev_q      <= cs_prev_d;
      rd_prev_q      <= rd_prev_d;
      wr_prev_q      <= wr_prev_d;
      state_q        <= state_d;
      tmo_cnt_q      <= tmo_cnt_d;
      data_buf_q     <= data_buf_d;
      ad_out_q       <= ad_out_d;
      ad_oe_q        <= ad_oe_d;
      mem_addr_q     <= mem_addr_d;
      mem_rd_req_q   <= mem_rd_req_d;
      busy_q         <= busy_d;
      err_underrun_q <= err_underrun_d;
      err_timeout_q  <= err_timeout_d;
      wr_ignored_q   <= wr_ignored_d;
    end
  end

  assign ad_out       = ad_out_q;
  assign ad_oe        = ad_oe_q;
  assign mem_addr     = mem_addr_q;
  assign mem_rd_req   = mem_rd_req_q;
  assign busy         = busy_q;
  assign err_underrun = err_underrun_q;
  assign err_timeout  = err_timeout_q;
  assign wr_ignored   = wr_ignored_q;

endmodule

// File: tb/tb_gba_rom_responder.sv
// Bench for gba_rom_responder: host/memory models drive random and directed
// ROM bursts; data and address sequences come from a simple ROM image function.
module tb_gba_rom_responder;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        nCS = 1'b1, nRD = 1'b1, nWR = 1'b1;
  logic [23:0] add_dat_in = '0;
  logic [15:0] ad_out, mem_data = '0;
  logic        ad_oe, mem_rd_req, mem_valid = 1'b0, busy;
  logic [23:0] mem_addr;
  logic        err_underrun, err_timeout, wr_ignored;

  int vectors = 0, miscompares = 0;
  int mem_lat = 3;
  int wr_cnt = 0;
  logic [23:0] got_q[$];

  gba_rom_responder dut (
    .clk(clk), .rst_n(rst_n), .nCS(nCS), .nRD(nRD), .nWR(nWR),
    .add_dat_in(add_dat_in), .ad_out(ad_out), .ad_oe(ad_oe),
    .mem_addr(mem_addr), .mem_rd_req(mem_rd_req), .mem_data(mem_data),
    .mem_valid(mem_valid), .busy(busy), .err_underrun(err_underrun),
    .err_timeout(err_timeout), .wr_ignored(wr_ignored)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] romval(input logic [23:0] a);
    return a[15:0] ^ {a[23:16], a[23:16]};
  endfunction

  function automatic logic [23:0] seq_addr(input logic [23:0] base, input int k);
    logic [15:0] lo;
    lo = 16'(base[15:0] + k);
    return {base[23:16], lo};
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Backing store: records every fetch address and answers after mem_lat clks.
  initial begin
    logic [23:0] a;
    forever begin
      @(posedge clk); #1;
      if (mem_rd_req === 1'b1) begin
        a = mem_addr;
        got_q.push_back(a);
        if (mem_lat >= 0) begin
          repeat (mem_lat) begin @(posedge clk); #1; end
          mem_valid = 1'b1;
          mem_data  = romval(a);
          @(posedge clk); #1;
          mem_valid = 1'b0;
        end
      end
    end
  end

  always @(negedge clk) if (wr_ignored === 1'b1) wr_cnt <= wr_cnt + 1;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_oe(input string tag, input logic v);
    int n = 0;
    while (ad_oe !== v && n < 40) begin @(negedge clk); n++; end
    chk(tag, ad_oe, v);
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    tick(6);
    while (busy !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    chk(tag, busy, 0);
  endtask

  task automatic read_one(input string tag, input logic [15:0] exp);
    wait_ready({tag, ".rdy"});
    nRD = 1'b0;
    wait_oe({tag, ".oe_on"}, 1'b1);
    chk({tag, ".data"}, ad_out, exp);
    tick(2);
    nRD = 1'b1;
    wait_oe({tag, ".oe_off"}, 1'b0);
  endtask

  task automatic check_reqs(input string tag, input logic [23:0] base, input int n);
    chk({tag, ".nreq"}, got_q.size(), n);
    for (int k = 0; k < n; k++)
      if (got_q.size() > 0) chk({tag, ".addr"}, got_q.pop_front(), seq_addr(base, k));
    got_q.delete();
  endtask

  task automatic burst(input string tag, input logic [23:0] base, input int len);
    add_dat_in = base;
    nCS = 1'b0;
    for (int k = 0; k < len; k++) read_one(tag, romval(seq_addr(base, k)));
    tick(2);
    nCS = 1'b1;
    tick(mem_lat + 12);
    chk({tag, ".end_addr"}, mem_addr, seq_addr(base, len));
    check_reqs(tag, base, len + 1);
    chk({tag, ".err_u"}, err_underrun, 0);
    chk({tag, ".err_t"}, err_timeout, 0);
  endtask

  task automatic do_reset();
    nCS = 1'b1; nRD = 1'b1; nWR = 1'b1;
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    got_q.delete();
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".ad_out"}, ad_out, 0);
    chk({tag, ".ad_oe"}, ad_oe, 0);
    chk({tag, ".mem_addr"}, mem_addr, 0);
    chk({tag, ".rd_req"}, mem_rd_req, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".err_u"}, err_underrun, 0);
    chk({tag, ".err_t"}, err_timeout, 0);
    chk({tag, ".wr_ign"}, wr_ignored, 0);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, w0;
    logic [23:0] base;

    tick(3);
    chk_all_zero("reset");
    rst_n = 1'b1;
    tick(2);

    mem_lat = 3;
    burst("single", 24'h000100, 1);
    burst("burst4", 24'h000100, 4);
    burst("wrap", 24'h12FFFF, 2);

    for (int i = 0; i < 40; i++) begin
      mem_lat = $urandom_range(0, 8);
      base = 24'($urandom);
      burst("rand", base, $urandom_range(1, 4));
      tick($urandom_range(0, 5));
    end

    // Write strobes are acknowledged only while selected and change nothing else.
    mem_lat = 2;
    w0 = wr_cnt;
    add_dat_in = 24'h000200;
    nCS = 1'b0;
    wait_ready("wr.rdy");
    nWR = 1'b0; tick(3); nWR = 1'b1; tick(6);
    chk("wr.pulses", wr_cnt - w0, 1);
    chk("wr.busy", busy, 0);
    chk("wr.addr", mem_addr, 24'h000200);
    read_one("wr.read", romval(24'h000200));
    tick(2); nCS = 1'b1; tick(15);
    check_reqs("wr", 24'h000200, 2);
    w0 = wr_cnt;
    nWR = 1'b0; tick(3); nWR = 1'b1; tick(6);
    chk("wr.unsel", wr_cnt - w0, 0);

    // Underrun: nRD drops long before the slow fetch returns.
    do_reset();
    mem_lat = 20;
    add_dat_in = 24'h000300;
    nCS = 1'b0;
    tick(5);
    nRD = 1'b0;
    wait_oe("und.oe", 1'b1);
    chk("und.flag", err_underrun, 1);
    chk("und.stale", ad_out, 0);
    n = 0;
    while (ad_out !== romval(24'h000300) && n < 40) begin @(negedge clk); n++; end
    chk("und.fresh", ad_out, romval(24'h000300));
    chk("und.oe_hold", ad_oe, 1);
    nRD = 1'b1;
    wait_oe("und.oe_off", 1'b0);
    tick(3); nCS = 1'b1; tick(35);
    check_reqs("und", 24'h000300, 2);
    chk("und.sticky", err_underrun, 1);

    // Timeout: memory never answers.
    do_reset();
    mem_lat = -1;
    add_dat_in = 24'h000400;
    nCS = 1'b0;
    tick(200);
    chk("tmo.early", err_timeout, 0);
    chk("tmo.busy", busy, 1);
    tick(70);
    chk("tmo.flag", err_timeout, 1);
    chk("tmo.done", busy, 0);
    nRD = 1'b0;
    wait_oe("tmo.oe", 1'b1);
    chk("tmo.data", ad_out, 16'hFFFF);
    chk("tmo.err_u", err_underrun, 0);
    nRD = 1'b1;
    wait_oe("tmo.oe_off", 1'b0);
    nCS = 1'b1; tick(5);

    // Abort: deselect mid-fetch, late mem_valid must not land in the buffer.
    do_reset();
    mem_lat = 10;
    add_dat_in = 24'h000500;
    nCS = 1'b0;
    tick(6);
    chk("abort.busy", busy, 1);
    nCS = 1'b1;
    tick(5);
    chk("abort.idle", busy, 0);
    chk("abort.oe", ad_oe, 0);
    tick(15);
    chk("abort.addr", mem_addr, 24'h000500);
    nRD = 1'b0; tick(6);
    chk("abort.nrd_idle", ad_oe, 0);
    nRD = 1'b1; tick(4);
    mem_lat = 20;
    add_dat_in = 24'h000600;
    nCS = 1'b0;
    tick(5);
    nRD = 1'b0;
    wait_oe("abort.und_oe", 1'b1);
    chk("abort.buf", ad_out, 0);
    tick(30);
    nRD = 1'b1; tick(4); nCS = 1'b1; tick(35);

    // Reset while driving the bus.
    mem_lat = 2;
    add_dat_in = 24'h000700;
    nCS = 1'b0;
    wait_ready("rst.rdy");
    nRD = 1'b0;
    wait_oe("rst.oe", 1'b1);
    rst_n = 1'b0;
    tick(1);
    chk_all_zero("rst_drive");
    nRD = 1'b1; nCS = 1'b1;
    tick(3);
    rst_n = 1'b1;
    tick(3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/gba_rom_responder.md
Name: gba_rom_responder

Overview:
- Cartridge-side responder for the GBA ROM bus. It emulates a ROM cartridge so the cart-reader host logic can be exercised without real hardware.
- Oversamples host-driven nCS/nRD/nWR with the system clock and latches the 24-bit halfword address from the multiplexed AD bus.
- Autoincrements the address on each read strobe and returns 16-bit data fetched from a backing-store port (BRAM/SDRAM wrapper).

Parameters:
- SYNC_STAGES, 2, synchronizer depth on nCS/nRD/nWR and AD inputs (min 2).
- FETCH_TIMEOUT, 255, clk cycles allowed for mem_valid before the fetch aborts with err_timeout.

Ports:
- clk  input  1  system clock, all logic rising-edge.
- rst_n  input  1  synchronous active-low reset.
- nCS  input  1  ROM chip select from host, active low.
- nRD  input  1  read strobe from host, active low.
- nWR  input  1  write strobe from host, active low.
- add_dat_in  input  24  sampled AD bus (address phase: A[23:0]; data phase ignored).
- ad_out  output  16  data driven onto AD[15:0] during reads.
- ad_oe  output  1  1 = responder drives AD[15:0]; top level tristates when 0.
- mem_addr  output  24  halfword address to backing store.
- mem_rd_req  output  1  one-cycle fetch request pulse.
- mem_data  input  16  backing-store read data.
- mem_valid  input  1  one-cycle pulse, mem_data valid.
- busy  output  1  1 while a fetch is outstanding.
- err_underrun  output  1  sticky; nRD fell before data was ready.
- err_timeout  output  1  sticky; a fetch exceeded FETCH_TIMEOUT.
- wr_ignored  output  1  one-cycle pulse per nWR falling edge while nCS is low (ROM is read-only).

Behaviour:
- Reset (rst_n=0 at clk edge): ad_out=0, ad_oe=0, mem_addr=0, mem_rd_req=0, busy=0, err_underrun=0, err_timeout=0, wr_ignored=0, state=IDLE, data_buf empty. Reset overrides any in-progress cycle.
- Synchronization and edge detection:
  - Inputs pass through SYNC_STAGES flops.
  - Edges are detected on the synchronized value versus its previous value, so the detect pulse lags the pin by SYNC_STAGES+1 clks.
  - add_dat_in is captured from the same synchronizer stage as nCS.
- States:
  - IDLE:
    - ad_oe=0.
    - On nCS fall with nRD high: mem_addr<=add_dat_in and go to FETCH.
    - nCS fall while nRD is already low: latch the address anyway and go to FETCH (host violation tolerated).
  - FETCH:
    - mem_rd_req=1 for exactly the first cycle of the state; busy=1 for the whole state.
    - On mem_valid: data_buf<=mem_data, busy=0, go to READY.
    - If the timeout counter reaches FETCH_TIMEOUT: set err_timeout, data_buf<=16'hFFFF, go to READY.
  - READY:
    - data valid and waiting.
    - When synchronized nRD is low: ad_out<=data_buf, ad_oe<=1, go to DRIVE. ad_oe asserts 1 clk after nRD is seen low.
  - DRIVE:
    - Hold ad_out and ad_oe.
    - On nRD rise: ad_oe<=0 on the same edge; mem_addr[15:0]<=mem_addr[15:0]+1, wrapping 16'hFFFF->16'h0000; mem_addr[23:16] unchanged; go to FETCH.
- Underrun:
  - If nRD is seen low while in FETCH: set err_underrun and drive the previous data_buf (0 after reset) with ad_oe=1.
  - When mem_valid arrives, update ad_out immediately if nRD is still low, then behave as DRIVE.
- nCS rise in any state:
  - ad_oe<=0 and go to IDLE next cycle.
  - A pending fetch is abandoned: a later mem_valid is ignored.
  - mem_addr holds its value.
- nWR fall with nCS low: pulse wr_ignored for 1 clk. State and address are unaffected.
- Simultaneous nRD rise and nCS rise detected on the same clk: nCS wins. No increment, go to IDLE.
- The error flags clear only on reset.

Test Plan:
- Single read: nCS fall with AD=24'h000100 → mem_addr=24'h000100 and one mem_rd_req pulse. mem_valid with 16'hBEEF after 3 clks, then nRD low → ad_oe=1, ad_out=16'hBEEF.
- Burst of 4: after the first read, three more nRD pulses (memory returns addr[15:0]) → ad_out sequence 0100,0101,0102,0103; mem_addr ends at 24'h000104.
- Wrap: start address 24'h12FFFF, two reads → second mem_addr=24'h120000 (bank 8'h12 preserved), ad_oe low between strobes.
- Underrun: memory delays mem_valid 20 clks, nRD low at 5 clks → err_underrun=1; ad_out goes 0 then 16'hxxxx (new data) once mem_valid arrives.
- Timeout and abort: never assert mem_valid → err_timeout=1 after 255 clks and ad_out=16'hFFFF on the next read. Separately, nCS rise mid-FETCH → IDLE, ad_oe=0, late mem_valid ignored.
- Write and reset: nWR pulse under nCS → one wr_ignored pulse, no state change. rst_n low during DRIVE → all outputs 0 on the next clk.
